masked_sram_1r1w: RTL
=====================

MASKED_SRAM_1R1W -- requirements
Module: masked_sram_1r1w

Interface
REQ-001 The block SHALL take these parameters (name, default, meaning):
- DEPTH, 64, number of rows; 2 to 4096, not required to be a power of 2.
- WIDTH, 184, bits per row.
- MASK_BITS, 8, write-mask lanes; WIDTH % MASK_BITS == 0; lane width LW = WIDTH/MASK_BITS.
- ADDR_W, clog2(DEPTH), derived and not overridable.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, single clock for all logic.
- reset, in, 1, synchronous, active-high.
- flush, in, 1, one-cycle pulse that restarts the zero-fill sweep.
- R0_addr, in, ADDR_W, read row.
- R0_en, in, 1, read request.
- R0_data, out, WIDTH, read result.
- W0_addr, in, ADDR_W, write row.
- W0_en, in, 1, write request.
- W0_data, in, WIDTH, write data.
- W0_mask, in, MASK_BITS, lane k covers W0_data[k*LW +: LW].
- init_done, out, 1, high when the array is zeroed and accepting operations.

REQ-003 There SHALL be one clock domain, and reset SHALL be synchronous and active-high, as fixed above.

Function
REQ-004 The block SHALL implement a two-state FSM: INIT (zero-fill sweep) and READY.
REQ-005 INIT SHALL use a sweep counter cnt that starts at 0 and writes all-zero to row cnt each cycle, incrementing by 1.
- The write to row DEPTH-1 SHALL move the FSM to READY on the same edge.
- INIT therefore lasts exactly DEPTH cycles.
REQ-006 init_done SHALL be 1 only in READY.
REQ-007 In INIT, R0_en and W0_en SHALL be ignored: no array update other than the sweep, and R0_data is unchanged.
REQ-008 In READY, with W0_en=1, each lane k with W0_mask[k]=1 SHALL be written at the clock edge; lanes with mask 0 SHALL keep their contents.
REQ-009 Read latency SHALL be 1: with R0_en=1 at edge N, R0_data SHALL show the row contents from edge N onward (valid in cycle N+1).
REQ-010 R0_data SHALL hold its last value while R0_en=0 and SHALL never be X.
REQ-011 On a read and write to the same row in the same cycle, the read SHALL be write-first per lane:
- masked-on lanes return the new W0_data lane;
- masked-off lanes return the old contents.
REQ-012 Reads and writes to different rows in the same cycle SHALL both complete with no interaction.
REQ-013 An address >= DEPTH (non-power-of-2 DEPTH only) SHALL make the write a no-op and the read return all zeros.
REQ-014 W0_en=1 with W0_mask=0 SHALL leave the array unchanged.
REQ-015 flush=1 in any state SHALL, at the next edge:
- enter INIT with cnt=0;
- clear init_done;
- ignore any R0_en or W0_en in that same cycle.
REQ-016 flush during INIT SHALL restart the sweep at row 0, so INIT ends DEPTH cycles after the last flush.
REQ-017 R0_data SHALL NOT be cleared by flush; it holds until the next accepted read.

Reset
REQ-018 While reset=1 at an edge, the block SHALL set:
- FSM to INIT;
- cnt to 0;
- init_done to 0;
- R0_data to all zeros.
REQ-019 reset SHALL take priority over flush, R0_en and W0_en.
REQ-020 Array contents SHALL NOT be required to clear on the reset edge; they are cleared by the INIT sweep that follows.
REQ-021 Reset asserted mid-sweep or mid-operation SHALL restart the sweep from row 0 on the first edge with reset=0.

Verification
REQ-022 The bench SHALL cover these scenarios:
- Reset then idle (defaults): init_done=0 for cycles 1..64 after reset release, init_done=1 at cycle 65; a read of every row returns 184'h0.
- Masked write: write row 5, data all-ones, mask 8'b0000_0101, then read row 5 -> bits [22:0] and [68:46] are 1, all other bits 0; one cycle later with R0_en=0, R0_data is unchanged.
- Same-row collision: row 9 holds 184'hA..A; in one cycle write row 9 with data 0 and mask 8'h01, and read row 9 -> R0_data[22:0]=0, R0_data[183:23] unchanged A pattern.
- Flush mid-operation: 3 cycles after flush, issue W0_en to row 0 -> write ignored; init_done returns after 64 cycles; row 0 reads 0.
- Flush in INIT and reset in INIT: flush at sweep cycle 30 -> init_done rises 64 cycles after the flush; reset at sweep cycle 40 -> same result measured from reset release, with R0_data=0 during reset.
- Non-power-of-2 configuration (DEPTH=48, WIDTH=32, MASK_BITS=4): write row 50 -> no change to any row; read row 50 -> 32'h0; INIT lasts 48 cycles.

Source files
------------

// File: rtl/masked_sram_1r1w.sv
// masked_sram_1r1w: 1-read/1-write SRAM with per-lane write mask, write-first
// same-row bypass, and a zero-fill sweep on reset or flush before accepting traffic.

// One write-mask lane: LW-bit storage column plus its slice of the read register.
module masked_sram_lane #(
  parameter int DEPTH  = 64,
  parameter int LW     = 23,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [LW-1:0]     wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic              rzero,
  output logic [LW-1:0]     rdata
);
  logic [LW-1:0] mem_q [DEPTH];
  logic [LW-1:0] rdata_d, rdata_q;

  // Read mux: out-of-range reads give zero; same-row write wins in this lane.
  always_comb begin
    rdata_d = rdata_q;
    if (re) begin
      if (rzero)                    rdata_d = '0;
      else if (we && waddr == raddr) rdata_d = wdata;
      else                           rdata_d = mem_q[raddr];
    end
  end

  // Read register holds between accepted reads and clears only on reset.
  always_ff @(posedge clock) begin
    if (reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  // Storage column; contents are cleared by the sweep, not by reset.
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = rdata_q;
endmodule

// Top: sweep FSM, address range checks, lane array.
module masked_sram_1r1w #(
  parameter  int DEPTH     = 64,
  parameter  int WIDTH     = 184,
  parameter  int MASK_BITS = 8,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [ADDR_W-1:0]    R0_addr,
  input  logic                 R0_en,
  output logic [WIDTH-1:0]     R0_data,
  input  logic [ADDR_W-1:0]    W0_addr,
  input  logic                 W0_en,
  input  logic [WIDTH-1:0]     W0_data,
  input  logic [MASK_BITS-1:0] W0_mask,
  output logic                 init_done
);
  localparam int                LW      = WIDTH / MASK_BITS;
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

  typedef enum logic {S_INIT, S_READY} state_e;

  state_e            state_d, state_q;
  logic [ADDR_W-1:0] cnt_d, cnt_q;
  logic              init_done_d, init_done_q;

  logic                          sweep, acc, w_ok, r_ok;
  logic [ADDR_W-1:0]             waddr;
  logic [MASK_BITS-1:0]          lane_we;
  logic [MASK_BITS-1:0][LW-1:0]  wdin, wlane, rlane;

  // Next state: flush restarts the sweep; the write of the last row ends INIT.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    init_done_d = init_done_q;
    if (flush) begin
      state_d     = S_INIT;
      cnt_d       = '0;
      init_done_d = 1'b0;
    end else if (state_q == S_INIT) begin
      if (cnt_q == LAST) begin
        state_d     = S_READY;
        cnt_d       = '0;
        init_done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // FSM, sweep counter and init_done register; reset overrides everything.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_INIT;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Port gating: sweep owns the write port in INIT; user ops only in READY.
  always_comb begin
    sweep = (state_q == S_INIT)  && !flush && !reset;
    acc   = (state_q == S_READY) && !flush && !reset;
    w_ok  = {1'b0, W0_addr} < DEPTH_C;
    r_ok  = {1'b0, R0_addr} < DEPTH_C;
    waddr = sweep ? cnt_q : W0_addr;
    wdin  = W0_data;
    wlane = sweep ? '0 : wdin;
    for (int k = 0; k < MASK_BITS; k++)
      lane_we[k] = sweep | (acc & W0_en & W0_mask[k] & w_ok);
  end

  for (genvar k = 0; k < MASK_BITS; k++) begin : g_lane
    masked_sram_lane #(.DEPTH(DEPTH), .LW(LW), .ADDR_W(ADDR_W)) u_lane (
      .clock (clock),
      .reset (reset),
      .we    (lane_we[k]),
      .waddr (waddr),
      .wdata (wlane[k]),
      .re    (acc & R0_en),
      .raddr (R0_addr),
      .rzero (~r_ok),
      .rdata (rlane[k])
    );
  end

  assign R0_data   = rlane;
  assign init_done = init_done_q;
endmodule
